// File: rtl/student_fir_i2s_tx_if.sv
// FIR result bus: a valid strobe and the wide signed accumulator sum.
// master drives valid_strobe_in / y_in; slave (the I2S transmitter) samples them.
interface student_fir_i2s_tx_if #(
  parameter int DATA_SIZE_FIR_OUT = 32
);
  logic                         valid_strobe_in;
  logic [DATA_SIZE_FIR_OUT-1:0] y_in;

  modport master (
    output valid_strobe_in,
    output y_in
  );

  modport slave (
    input valid_strobe_in,
    input y_in
  );
endinterface

// File: rtl/student_fir_i2s_tx.sv
// FIR output to mono I2S: shift + saturate to PCM, FIFO buffer, serialize L=R.
// Ports: clk_i, rst_i (sync, high), fir (slave bus), enable_i, clear_i,
//   i2s_bclk_o/lrclk_o/sd_o, fifo_level_o, overflow_o, underrun_o (sticky).
module student_fir_i2s_tx #(
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int DATA_SIZE         = 16,
  parameter int SHIFT             = 15,
  parameter int FIFO_DEPTH        = 4,
  parameter int BCLK_DIV          = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  student_fir_i2s_tx_if.slave              fir,
  input  logic                             enable_i,
  input  logic                             clear_i,
  output logic                             i2s_bclk_o,
  output logic                             i2s_lrclk_o,
  output logic                             i2s_sd_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             overflow_o,
  output logic                             underrun_o
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CW = $clog2(2 * DATA_SIZE);
  localparam int IW = $clog2(DATA_SIZE);

  localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SAT_HI =
    DATA_SIZE_FIR_OUT'((1 << (DATA_SIZE - 1)) - 1);
  localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SAT_LO = ~SAT_HI;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DATA_SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic                 prev_q, prev_d;
  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 bclk_q, bclk_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sd_q, sd_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic                 ovf_q, ovf_d;
  logic                 udr_q, udr_d;

  logic signed [DATA_SIZE_FIR_OUT-1:0] t_s;
  logic [DATA_SIZE-1:0] pcm;
  logic                 push_ev, push, pop;
  logic                 div_end, fall;
  logic                 ovf_set, udr_set;
  logic [IW-1:0]        idx;

  // Rescale the FIR sum to PCM
  always_comb begin
    t_s = $signed(fir.y_in) >>> SHIFT;
    pcm = t_s[DATA_SIZE-1:0];
    if (t_s > SAT_HI) begin
      pcm = {1'b0, {(DATA_SIZE-1){1'b1}}};
    end else if (t_s < SAT_LO) begin
      pcm = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end
  end

  // Serializer: divider, bit counter, word load and bit select
  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    cnt_d   = cnt_q;
    lrclk_d = lrclk_q;
    sd_d    = sd_q;
    word_d  = word_q;
    pop     = 1'b0;
    udr_set = 1'b0;
    idx     = '0;
    div_end = (div_q == DIV_LAST);
    fall    = enable_i & div_end & bclk_q;
    if (!enable_i) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      cnt_d   = '0;
      lrclk_d = 1'b0;
      sd_d    = 1'b0;
      word_d  = '0;
    end else begin
      div_d = div_end ? '0 : div_q + 1'b1;
      if (div_end) begin
        bclk_d = ~bclk_q;
      end
      if (fall) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        // Leaving bit 0: the word register has just shifted out its last
        // right-slot bit, so it is free to take the next FIFO entry.
        if (cnt_q == '0) begin
          if (level_q != '0) begin
            pop    = 1'b1;
            word_d = mem_q[rd_ptr_q];
          end else begin
            word_d  = '0;
            udr_set = 1'b1;
          end
        end
        if (cnt_d == '0) begin
          idx = '0;
        end else if (cnt_d <= CW'(DATA_SIZE)) begin
          idx = IW'(DATA_SIZE - int'(cnt_d));
        end else begin
          idx = IW'(2 * DATA_SIZE - int'(cnt_d));
        end
        lrclk_d = (cnt_d >= CW'(DATA_SIZE));
        sd_d    = word_d[idx];
      end
    end
  end

  // FIFO bookkeeping and sticky flags
  always_comb begin
    prev_d   = fir.valid_strobe_in;
    push_ev  = fir.valid_strobe_in & ~prev_q;
    // A full FIFO still takes the sample when the head leaves this cycle
    push     = push_ev & ((level_q != LW'(FIFO_DEPTH)) | pop);
    ovf_set  = push_ev & ~push;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~clear_i);
    udr_d = udr_set | (udr_q & ~clear_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      div_q    <= '0;
      bclk_q   <= 1'b0;
      cnt_q    <= '0;
      lrclk_q  <= 1'b0;
      sd_q     <= 1'b0;
      word_q   <= '0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      cnt_q    <= cnt_d;
      lrclk_q  <= lrclk_d;
      sd_q     <= sd_d;
      word_q   <= word_d;
      ovf_q    <= ovf_d;
      udr_q    <= udr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= pcm;
    end
  end

  assign i2s_bclk_o   = bclk_q;
  assign i2s_lrclk_o  = lrclk_q;
  assign i2s_sd_o     = sd_q;
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;
  assign underrun_o   = udr_q;

endmodule

// File: tb/tb_student_fir_i2s_tx.sv
// Bench for student_fir_i2s_tx: scoreboard of PCM words vs received I2S slots,
// plus per-cycle checks of bclk/lrclk/level/flags against a closed-form model.
module tb_student_fir_i2s_tx;

  localparam int D     = 16;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * D * DIV;

  logic        clk;
  logic        rst_i;
  logic        enable_i;
  logic        clear_i;
  logic        i2s_bclk_o;
  logic        i2s_lrclk_o;
  logic        i2s_sd_o;
  logic [2:0]  fifo_level_o;
  logic        overflow_o;
  logic        underrun_o;
  logic [15:0] exp_in;

  student_fir_i2s_tx_if #(.DATA_SIZE_FIR_OUT(32)) fir_bus ();

  student_fir_i2s_tx #(
    .DATA_SIZE_FIR_OUT(32),
    .DATA_SIZE(D),
    .SHIFT(15),
    .FIFO_DEPTH(DEPTH),
    .BCLK_DIV(DIV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .fir(fir_bus),
    .enable_i(enable_i),
    .clear_i(clear_i),
    .i2s_bclk_o(i2s_bclk_o),
    .i2s_lrclk_o(i2s_lrclk_o),
    .i2s_sd_o(i2s_sd_o),
    .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o),
    .underrun_o(underrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec;
  int          n_err;
  int          k;
  logic [15:0] sb_q [$];
  logic [15:0] w_m;
  logic [15:0] sr;
  bit          prev_m;
  bit          ov_m;
  bit          ur_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // k = enabled clock edges since enable/reset; bclk toggles every DIV
  // edges, one bit per 2*DIV edges, word load at bit 1 (k mod FRAME == 8).
  task automatic model_step();
    bit ov_s;
    bit ur_s;
    bit pe;
    int n;
    ov_s = 1'b0;
    ur_s = 1'b0;
    if (rst_i) begin
      sb_q.delete();
      k      = 0;
      w_m    = '0;
      sr     = '0;
      prev_m = 1'b0;
      ov_m   = 1'b0;
      ur_m   = 1'b0;
    end else begin
      if (enable_i) begin
        k++;
        if (k % FRAME == 2 * DIV) begin
          if (sb_q.size() != 0) begin
            w_m = sb_q.pop_front();
          end else begin
            w_m  = '0;
            ur_s = 1'b1;
          end
        end
      end else begin
        k   = 0;
        w_m = '0;
      end
      pe     = fir_bus.valid_strobe_in && !prev_m;
      prev_m = fir_bus.valid_strobe_in;
      if (pe) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(exp_in);
        else ov_s = 1'b1;
      end
      ov_m = ov_s | (ov_m & !clear_i);
      ur_m = ur_s | (ur_m & !clear_i);
      if (enable_i && (k % (2 * DIV)) == DIV) begin
        n  = (k / (2 * DIV)) % (2 * D);
        sr = {sr[14:0], i2s_sd_o};
        if (n == D) begin
          chk("left", sr, w_m);
        end else if (n == 0) begin
          if (k < FRAME) chk("hold0", i2s_sd_o, 0);
          else chk("right", sr, w_m);
        end
      end
    end
    chk("bclk", i2s_bclk_o, (k / DIV) % 2);
    chk("lrclk", i2s_lrclk_o, ((k / (2 * DIV)) % (2 * D)) >= D);
    chk("level", fifo_level_o, sb_q.size());
    chk("ovf", overflow_o, ov_m);
    chk("udr", underrun_o, ur_m);
    if (k == 0) chk("sd_idle", i2s_sd_o, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic push(input logic [31:0] y, input logic [15:0] e,
                      input int width);
    fir_bus.y_in = y;
    exp_in = e;
    fir_bus.valid_strobe_in = 1'b1;
    repeat (width) tick();
    fir_bus.valid_strobe_in = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    k = 0;
    w_m = '0;
    sr = '0;
    prev_m = 1'b0;
    ov_m = 1'b0;
    ur_m = 1'b0;
    rst_i = 1'b1;
    enable_i = 1'b0;
    clear_i = 1'b0;
    exp_in = '0;
    fir_bus.valid_strobe_in = 1'b0;
    fir_bus.y_in = '0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("rst_lvl", fifo_level_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_udr", underrun_o, 0);

    // Fill while idle; the fifth sample must be dropped
    push(32'h1234_8000, 16'h2469, 1);
    push(32'h7FFF_FFFF, 16'h7FFF, 1);
    push(32'h8000_0000, 16'h8000, 1);
    push(32'hFFFF_8000, 16'hFFFF, 1);
    chk("ovf_pre", overflow_o, 0);
    push(32'h0000_7FFF, 16'h0000, 1);
    chk("lvl_full", fifo_level_o, 4);
    chk("ovf_set", overflow_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("ovf_clr", overflow_o, 0);

    // Four frames play the buffered words, the fifth underruns
    enable_i = 1'b1;
    repeat (4 * FRAME + 4) tick();
    chk("udr_pre", underrun_o, 0);
    repeat (8) tick();
    chk("udr_set", underrun_o, 1);

    // Strobe held for three cycles is one push
    push(32'h0000_8000, 16'h0001, 3);
    chk("strobe1", fifo_level_o, 1);
    while (k < 6 * FRAME + 2 * DIV) tick();

    push(32'h3FFF_8000, 16'h7FFF, 1);
    push(32'hBFFF_8000, 16'h8000, 1);
    push(32'h0000_7FFF, 16'h0000, 1);
    push(32'hFFFE_0000, 16'hFFFC, 1);
    chk("lvl4", fifo_level_o, 4);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("udr_clr", underrun_o, 0);

    // Push on the very edge that pops while full
    for (int i = 0; i < FRAME && (k % FRAME) != 2 * DIV - 1; i++) tick();
    chk("sync_pop", k % FRAME, 2 * DIV - 1);
    fir_bus.y_in = 32'h00FF_0000;
    exp_in = 16'h01FE;
    fir_bus.valid_strobe_in = 1'b1;
    tick();
    fir_bus.valid_strobe_in = 1'b0;
    chk("lvl_pp", fifo_level_o, 4);
    chk("ovf_pp", overflow_o, 0);
    while (k < 12 * FRAME + 2 * DIV) tick();

    // Reset in the middle of a right slot (bit 20)
    push(32'h0010_0000, 16'h0020, 1);
    for (int i = 0; i < FRAME && (k % FRAME) != 20 * 2 * DIV + 2; i++) tick();
    chk("sync_rst", k % FRAME, 20 * 2 * DIV + 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mr_lvl", fifo_level_o, 0);
    chk("mr_bclk", i2s_bclk_o, 0);
    chk("mr_lrclk", i2s_lrclk_o, 0);
    chk("mr_sd", i2s_sd_o, 0);
    chk("mr_udr", underrun_o, 0);
    push(32'hFFFF_8000, 16'hFFFF, 1);
    while (k < FRAME + 2 * DIV) tick();

    enable_i = 1'b0;
    tick();
    chk("dis_bclk", i2s_bclk_o, 0);
    chk("dis_sd", i2s_sd_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/student_fir_i2s_tx.md
Name: student_fir_i2s_tx

Overview:
Output-side counterpart of the FIR sample path. It consumes the FIR accumulator result (wide sum plus a one-cycle valid strobe) and rescales it with an arithmetic shift and saturation to 16-bit PCM. The result is buffered in a small FIFO and serialized as a mono I2S stream (same word on left and right) toward the audio DAC. It sits directly after the FIR, in the same clock domain.

Parameters:
DATA_SIZE_FIR_OUT, 32, width of incoming FIR sum (signed two's complement)
DATA_SIZE, 16, PCM word width; fixes slot length (frame = 2*DATA_SIZE bclk periods)
SHIFT, 15, arithmetic right shift applied before saturation (Q15 coefficients)
FIFO_DEPTH, 4, PCM words buffered (power of two, >=2)
BCLK_DIV, 4, clk_i cycles per bclk half-period (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
valid_strobe_in  in  1  FIR result valid; rising edge = one new sample
y_in  in  DATA_SIZE_FIR_OUT  FIR sum, signed
enable_i  in  1  1 = serializer runs; 0 = serializer idle, FIFO still accepts
clear_i  in  1  one-cycle pulse, clears sticky flags
i2s_bclk_o  out  1  bit clock
i2s_lrclk_o  out  1  word select, 0 = left, 1 = right
i2s_sd_o  out  1  serial data, MSB first, I2S one-bit delay
fifo_level_o  out  $clog2(FIFO_DEPTH+1)  words in FIFO
overflow_o  out  1  sticky: sample dropped, FIFO full
underrun_o  out  1  sticky: frame started with empty FIFO

Behaviour:
- Reset (rst_i=1 at clk edge): all outputs 0; FIFO emptied; bit_cnt=0; divider=0; hold word=0; edge detector prev=0. Reset mid-frame aborts the frame immediately.
- Interface: one clock, synchronous active-high reset; all outputs registered.
- Push event:
  - Occurs on valid_strobe_in & ~prev. A strobe held high for N cycles yields exactly one push.
- Conversion, same cycle as the push event:
  - t = y_in >>> SHIFT (signed).
  - s = t saturated to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- Push acceptance:
  - Written if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise dropped, and overflow_o=1 from the next cycle.
  - fifo_level_o updates the cycle after push/pop; simultaneous push and pop leaves it unchanged.
- Sticky flags: cleared by clear_i. If set and clear occur in the same cycle, set wins.
- Serializer, enable_i=0:
  - bclk, lrclk and sd are 0; divider=0; bit_cnt=0; hold word=0.
  - Dropping enable mid-frame stops immediately; no pop occurs.
- Serializer, enable_i=1:
  - Divider counts 0..BCLK_DIV-1; at terminal count, bclk toggles. First rising bclk occurs BCLK_DIV cycles after enable is seen high.
  - On each bclk falling transition, bit_cnt increments mod 2*DATA_SIZE. sd and lrclk change only on the falling transition; the DAC samples on the rising edge.
- lrclk_o: 0 for bit_cnt 0..DATA_SIZE-1, 1 for bit_cnt DATA_SIZE..2*DATA_SIZE-1.
- Word load: on the falling transition into bit_cnt=1, pop the FIFO head into the current word W.
  - Previous W is retained as hold word H.
  - If the FIFO is empty, W=0 and underrun_o=1.
- sd_o mapping (one-bit delay, D=DATA_SIZE):
  - bit_cnt=0: H[0].
  - bit_cnt=n in 1..D: W[D-n] (left slot).
  - bit_cnt=D+1..2D-1: W[2D-n] (right slot, bits D-1..1).
  - Right bit 0 appears at bit_cnt=0 of the next frame.
- Frame period: 4*DATA_SIZE*BCLK_DIV clk cycles (default 256), one PCM word per frame.

Test Plan:
1. Conversion: SHIFT=15, y_in=0x1234_8000, enable=1 → left and right slots both serialize 0x2469 MSB first. Bit 15 appears one bclk after the lrclk fall; right bit 0 appears at bit_cnt 0 of the following frame.
2. Saturation: y_in 0x7FFF_FFFF → 0x7FFF; 0x8000_0000 → 0x8000; 0xFFFF_8000 → 0xFFFF; 0x0000_7FFF → 0x0000.
3. Overflow: enable=0, 5 single-cycle strobes with distinct values → fifo_level_o=4, overflow_o=1. After enable, the first 4 values play in order and the 5th is absent. clear_i → overflow_o=0 next cycle.
4. Underrun: enable=1 with empty FIFO → sd_o=0 for the whole frame, underrun_o=1. Push 0x0001 → next frame carries 0x0001.
5. Strobe width: valid_strobe_in high for 3 cycles → exactly one push, fifo_level_o=1. Push coinciding with the pop at bit_cnt→1 while level=4 → accepted, level stays 4.
6. Reset mid-frame: rst_i=1 for one cycle at bit_cnt=20 → next cycle all outputs and fifo_level_o are 0. The next frame begins with bit_cnt=0, H=0.
